pipelined_csel_adder: RTL
=========================

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 Parameter BLK, default 4: carry-select block width in bits.
REQ-003 Parameter BLK_PER_STAGE, default 1: carry-select blocks resolved per pipeline stage.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: an operation is offered on a, b, cin and sub.
REQ-007 Port in_ready, output, 1: the block accepts the offered operation this cycle.
REQ-008 Port a, input, WIDTH: first operand.
REQ-009 Port b, input, WIDTH: second operand.
REQ-010 Port cin, input, 1: carry-in in add mode; borrow-in in sub mode.
REQ-011 Port sub, input, 1: 0 = add, 1 = subtract.
REQ-012 Port out_valid, output, 1: sum, cout and ovf hold a result.
REQ-013 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-014 Port sum, output, WIDTH: result bits.
REQ-015 Port cout, output, 1: raw carry out of the MSB.
REQ-016 Port ovf, output, 1: two's-complement signed overflow.

Function
REQ-017 NSTAGE = WIDTH / (BLK*BLK_PER_STAGE); elaboration SHALL fail unless the division is exact and NSTAGE >= 1.
REQ-018 Add mode: {cout,sum} = a + b + cin. Sub mode: {cout,sum} = a + ~b + ~cin, which equals a - b - cin; cout = NOT borrow.
REQ-019 ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = sub ? ~b : b.
REQ-020 Stage k (0..NSTAGE-1) computes each of its blocks twice, with carry-in 0 and with carry-in 1, and selects by the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-021 Each stage register carries a valid bit, completed sum bits, the unconsumed operand bits, the inter-stage carry and the operand MSBs needed for ovf.
REQ-022 advance = !out_valid || out_ready; in_ready = advance (combinational); all stages shift together when advance = 1.
REQ-023 Accept occurs when in_valid && in_ready; the result appears with out_valid = 1 exactly NSTAGE cycles after accept when no stall occurs.
REQ-024 Throughput: one operation per cycle while out_ready = 1.
REQ-025 When advance = 0, every stage register, including sum, cout, ovf and out_valid, SHALL hold its value; no operation is lost, duplicated or reordered.
REQ-026 An in_valid = 0 cycle with advance = 1 SHALL insert a bubble (valid = 0) that travels the pipeline.
REQ-027 Invalid stage contents SHALL NOT affect any output bit; sum, cout and ovf hold their last valid values while out_valid = 0.
REQ-028 Full 2^WIDTH wrap-around: sum SHALL be the result modulo 2^WIDTH, with the carry reported only on cout.

Reset
REQ-029 While rst = 1 on a clock edge, all valid bits SHALL clear, and sum, cout and ovf SHALL be 0.
REQ-030 Reset mid-operation flushes all in-flight operations; none reaches the output.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.
REQ-032 An in_valid offered in the same cycle as rst = 1 SHALL NOT be accepted.

Structure
REQ-033 Shared package csel_pkg: mode enum (ADD = 0, SUB = 1) and the NSTAGE computation function.
REQ-034 Sub-module csel_block (combinational, BLK wide): computes both carry-in cases and selects the sum and carry-out; instantiated BLK_PER_STAGE times per stage via generate.

Verification (WIDTH=16, BLK=4, BLK_PER_STAGE=1, so NSTAGE=4)
REQ-035 Add a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0, out_valid high 4 cycles after accept.
REQ-036 Sub a=16'h0005, b=16'h0007, cin=0 -> sum=16'hFFFE, cout=0, ovf=0.
REQ-037 Add a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1; sub a=16'h8000, b=16'h0001 -> sum=16'h7FFF, ovf=1.
REQ-038 Stream 8 random operations back-to-back with out_ready low for 3 cycles mid-stream -> all 8 results arrive in order, outputs stay stable while stalled, and in_ready = 0 during the stall.
REQ-039 Accept 2 operations, assert rst at cycle 2 -> out_valid=0, sum=0 the next cycle, neither result ever appears, and in_ready=1.
REQ-040 Alternate in_valid 1/0 for 10 cycles with out_ready=1 -> results alternate with bubbles and match a reference model bit-exactly.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared definitions for the pipelined carry-select adder: operation mode and
// the stage-count calculation used to size and validate the pipeline.
package csel_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Returns 0 for any configuration that does not split evenly into stages.
  function automatic int calc_nstage(input int width, input int blk, input int blk_per_stage);
    int chunk;
    chunk = blk * blk_per_stage;
    if (chunk <= 0 || width <= 0 || (width % chunk) != 0) begin
      return 0;
    end
    return width / chunk;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: both carry-in cases are summed up front so the
// late-arriving carry only drives the final mux.
module csel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0] res_c0;
  logic [BLK:0] res_c1;

  assign res_c0 = {1'b0, a} + {1'b0, b};
  assign res_c1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

  assign sum  = cin ? res_c1[BLK-1:0] : res_c0[BLK-1:0];
  assign cout = cin ? res_c1[BLK]     : res_c0[BLK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake; each
// stage resolves BLK_PER_STAGE blocks and passes the carry to the next stage.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int BLK           = 4,
  parameter int BLK_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = calc_nstage(WIDTH, BLK, BLK_PER_STAGE);
  localparam int SW     = BLK * BLK_PER_STAGE;
  localparam int NS     = (NSTAGE < 1) ? 1 : NSTAGE;

  if (NSTAGE < 1) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLK*BLK_PER_STAGE");
  end

  mode_e            mode;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign mode     = mode_e'(sub);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = (mode == SUB) ? ~b : b;
  assign cin_eff  = (mode == SUB) ? ~cin : cin;

  for (genvar gi = 0; gi < NS; gi++) begin : g_stage
    localparam int LO   = gi * SW;
    localparam int DONE = LO + SW;
    localparam int REM  = WIDTH - DONE;

    logic                   v_in;
    logic                   c_in;
    logic                   a_msb_in;
    logic                   b_msb_in;
    logic [WIDTH-LO-1:0]    op_a;
    logic [WIDTH-LO-1:0]    op_b;
    logic [DONE-1:0]        sum_new;
    logic [SW-1:0]          blk_s;
    logic [BLK_PER_STAGE:0] chain;

    logic            valid_q, valid_d;
    logic            carry_q, carry_d;
    logic            a_msb_q, a_msb_d;
    logic            b_msb_q, b_msb_d;
    logic [DONE-1:0] sum_q, sum_d;

    // Stage 0 reads the ports; later stages read only the bits still unconsumed.
    if (gi == 0) begin : g_src
      assign v_in     = in_valid;
      assign c_in     = cin_eff;
      assign op_a     = a;
      assign op_b     = b_eff;
      assign a_msb_in = a[WIDTH-1];
      assign b_msb_in = b_eff[WIDTH-1];
      assign sum_new  = blk_s;
    end else begin : g_src
      assign v_in     = g_stage[gi-1].valid_q;
      assign c_in     = g_stage[gi-1].carry_q;
      assign op_a     = g_stage[gi-1].g_rem.rem_a_q;
      assign op_b     = g_stage[gi-1].g_rem.rem_b_q;
      assign a_msb_in = g_stage[gi-1].a_msb_q;
      assign b_msb_in = g_stage[gi-1].b_msb_q;
      assign sum_new  = {blk_s, g_stage[gi-1].sum_q};
    end

    assign chain[0] = c_in;
    for (genvar gj = 0; gj < BLK_PER_STAGE; gj++) begin : g_blk
      csel_block #(
        .BLK(BLK)
      ) u_blk (
        .a   (op_a[gj*BLK +: BLK]),
        .b   (op_b[gj*BLK +: BLK]),
        .cin (chain[gj]),
        .sum (blk_s[gj*BLK +: BLK]),
        .cout(chain[gj+1])
      );
    end

    // Data only loads with a valid op, so bubbles never disturb the outputs.
    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      sum_d   = sum_q;
      if (advance) begin
        valid_d = v_in;
        if (v_in) begin
          carry_d = chain[BLK_PER_STAGE];
          a_msb_d = a_msb_in;
          b_msb_d = b_msb_in;
          sum_d   = sum_new;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        a_msb_q <= 1'b0;
        b_msb_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        a_msb_q <= a_msb_d;
        b_msb_q <= b_msb_d;
        sum_q   <= sum_d;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] rem_a_q, rem_a_d;
      logic [REM-1:0] rem_b_q, rem_b_d;

      always_comb begin
        rem_a_d = rem_a_q;
        rem_b_d = rem_b_q;
        if (advance && v_in) begin
          rem_a_d = op_a[WIDTH-LO-1:SW];
          rem_b_d = op_b[WIDTH-LO-1:SW];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NS-1].valid_q;
  assign sum       = g_stage[NS-1].sum_q;
  assign cout      = g_stage[NS-1].carry_q;
  assign ovf       = (g_stage[NS-1].a_msb_q == g_stage[NS-1].b_msb_q) &&
                     (g_stage[NS-1].sum_q[WIDTH-1] != g_stage[NS-1].a_msb_q);

endmodule
